// File: rtl/sar_adc_seq.sv
// Successive-approximation sequencer for the PmodADC: sample/hold, serial DAC trial load, comparator judgement.
// Ready strobe SH_CYC + DATA_W*T_BIT + 1 cycles after start acceptance; start_i is ignored while busy_o is high.
module sar_adc_seq #(
    parameter int DATA_W     = 14,
    parameter int SHREG_W    = 16,
    parameter int CLK_DIV    = 2,
    parameter int SETTLE_CYC = 8,
    parameter int SH_CYC     = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              ADC_SH_o,
    output logic              ADC_Ser_o,
    output logic              ADC_SClk_o,
    output logic              ADC_LClk_o,
    input  logic              ADC_Comp_i,
    output logic [DATA_W-1:0] ADC_data_o,
    output logic              ADC_data_rdy_o
);

    localparam int MAX_A   = (SH_CYC > SETTLE_CYC) ? SH_CYC : SETTLE_CYC;
    localparam int CNT_MAX = (MAX_A > CLK_DIV) ? MAX_A : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (SHREG_W > 1) ? $clog2(SHREG_W) : 1;
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PAD     = SHREG_W - DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SHIFT,
        S_LATCH,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t             state;
    logic [1:0]         comp_sync;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  acc_next;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [SHREG_W-1:0] word_cur;
    logic [SHREG_W-1:0] word_next;

    // acc always holds the current trial code (bit idx set); acc_next is the post-decision trial.
    always_comb begin
        word_cur = SHREG_W'(acc) << PAD;
        acc_next = acc;
        if (!comp_sync[1]) begin
            acc_next[idx] = 1'b0;
        end
        if (idx != '0) begin
            acc_next[idx - 1'b1] = 1'b1;
        end
        word_next = SHREG_W'(acc_next) << PAD;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= S_IDLE;
            comp_sync      <= '0;
            acc            <= '0;
            idx            <= '0;
            cnt            <= '0;
            bit_cnt        <= '0;
            busy_o         <= 1'b0;
            ADC_SH_o       <= 1'b0;
            ADC_Ser_o      <= 1'b0;
            ADC_SClk_o     <= 1'b0;
            ADC_LClk_o     <= 1'b0;
            ADC_data_o     <= '0;
            ADC_data_rdy_o <= 1'b0;
        end else begin
            comp_sync <= {comp_sync[0], ADC_Comp_i};
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        acc    <= DATA_W'(1) << (DATA_W - 1);
                        idx    <= IDX_W'(DATA_W - 1);
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= S_SAMPLE;
                    end
                end
                // First SAMPLE cycle raises SH; SH then stays high for SH_CYC cycles.
                S_SAMPLE: begin
                    if (cnt == CNT_W'(SH_CYC)) begin
                        ADC_SH_o   <= 1'b0;
                        ADC_Ser_o  <= word_cur[0];
                        ADC_SClk_o <= 1'b0;
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        state      <= S_SHIFT;
                    end else begin
                        ADC_SH_o <= 1'b1;
                        cnt      <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt <= '0;
                        if (!ADC_SClk_o) begin
                            ADC_SClk_o <= 1'b1;
                        end else if (bit_cnt == BIT_W'(SHREG_W - 1)) begin
                            ADC_SClk_o <= 1'b0;
                            ADC_Ser_o  <= 1'b0;
                            ADC_LClk_o <= 1'b1;
                            state      <= S_LATCH;
                        end else begin
                            ADC_SClk_o <= 1'b0;
                            ADC_Ser_o  <= word_cur[bit_cnt + 1'b1];
                            bit_cnt    <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        ADC_LClk_o <= 1'b0;
                        cnt        <= '0;
                        state      <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DECIDE: begin
                    acc <= acc_next;
                    if (idx != '0) begin
                        idx       <= idx - 1'b1;
                        ADC_Ser_o <= word_next[0];
                        bit_cnt   <= '0;
                        state     <= S_SHIFT;
                    end else begin
                        ADC_data_o     <= acc_next;
                        ADC_data_rdy_o <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                // Strobe and busy are both visible in this cycle.
                S_DONE: begin
                    ADC_data_rdy_o <= 1'b0;
                    busy_o         <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_seq.sv
// Bench for sar_adc_seq: emulated 16-bit serial DAC plus comparator, binary-search reference model.
module tb_sar_adc_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, sh, ser, sclk, lclk, comp, rdy;
    logic [13:0] data;

    always #5 clk = ~clk;

    sar_adc_seq dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .busy_o         (busy),
        .ADC_SH_o       (sh),
        .ADC_Ser_o      (ser),
        .ADC_SClk_o     (sclk),
        .ADC_LClk_o     (lclk),
        .ADC_Comp_i     (comp),
        .ADC_data_o     (data),
        .ADC_data_rdy_o (rdy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Emulated board: mode 0 = compare latched word against thr, 1 = tied high, 2 = tied low.
    int          mode = 0;
    logic [15:0] thr = 16'h2FFF;
    logic [15:0] dac_sr = '0;
    logic [15:0] dac_lat = '0;
    logic [15:0] lat_q[$];

    always @(posedge sclk) dac_sr <= {ser, dac_sr[15:1]};
    always @(posedge lclk) begin
        dac_lat <= dac_sr;
        lat_q.push_back(dac_sr);
    end
    assign comp = (mode == 1) || (mode == 0 && dac_lat <= thr);

    int   sclk_rises = 0, lclk_rises = 0, sh_cycles = 0, overlap = 0;
    int   ser_err = 0, rdy_wide = 0, activity = 0;
    logic p_sclk = 1'b0, p_lclk = 1'b0, p_ser = 1'b0, p_rdy = 1'b0;

    always @(negedge clk) begin
        if (sclk === 1'b1 && p_sclk === 1'b0) begin
            sclk_rises++;
            if (ser !== p_ser) ser_err++;
        end
        if (sclk === 1'b1 && p_sclk === 1'b1 && ser !== p_ser) ser_err++;
        if (lclk === 1'b1 && p_lclk === 1'b0) lclk_rises++;
        if (sh === 1'b1) sh_cycles++;
        if (sh === 1'b1 && sclk === 1'b1) overlap++;
        if (sh === 1'b1 || sclk === 1'b1 || lclk === 1'b1) activity++;
        if (rdy === 1'b1 && p_rdy === 1'b1) rdy_wide++;
        p_sclk = sclk;
        p_lclk = lclk;
        p_ser  = ser;
        p_rdy  = rdy;
    end

    // k < 14: k-th DAC word the search latches; k == 14: final result.
    function automatic int model(input int md, input int th, input int k);
        int r = 0;
        for (int b = 13; b >= 0; b--) begin
            int w = (r + (1 << b)) * 4;
            if (13 - b == k) return w;
            if (md == 1 || (md == 0 && w <= th)) r = r + (1 << b);
        end
        return r;
    endfunction

    int          acc_cyc, got_cyc;
    logic [13:0] got_data;
    logic        got_busy, after_rdy, after_busy;
    bit          timed_out;
    int          b_sclk, b_lclk, b_sh, b_ov, b_ser, b_wide, b_words;

    task automatic run_conv(input int md, input logic [15:0] th, input int pa, input int pb);
        mode = md;
        thr  = th;
        @(posedge clk); #1;
        b_sclk = sclk_rises; b_lclk = lclk_rises; b_sh = sh_cycles; b_ov = overlap;
        b_ser = ser_err; b_wide = rdy_wide; b_words = lat_q.size();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        acc_cyc = cyc;
        timed_out = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            start = (k == pa || k == pb);
            if (rdy === 1'b1) begin
                got_data  = data;
                got_cyc   = cyc;
                got_busy  = busy;
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        after_rdy  = rdy;
        after_busy = busy;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, sh, ser, sclk, lclk, rdy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000", {busy, sh, ser, sclk, lclk, rdy});
        end
        n_cmp++;
        if (data !== 14'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0000", data);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (activity !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_activity: got activity %0d busy %b want 0 0", activity, busy);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_midscale;
        run_conv(0, 16'h2FFF, -1, -1);
        n_cmp++;
        if (timed_out || got_data !== 14'(model(0, 'h2FFF, 14)) || got_data !== 14'h0BFF) begin
            n_err++;
            $display("FAIL mid_data: got %h timeout %0d want 0bff", got_data, timed_out);
        end
        n_cmp++;
        if (got_cyc - acc_cyc !== 1067) begin
            n_err++;
            $display("FAIL mid_latency: got %0d want 1067", got_cyc - acc_cyc);
        end
        n_cmp++;
        if (got_busy !== 1'b1 || after_busy !== 1'b0 || after_rdy !== 1'b0 || rdy_wide != b_wide) begin
            n_err++;
            $display("FAIL mid_strobe: got busy %b/%b rdy_after %b wide %0d want 1/0 0 0",
                     got_busy, after_busy, after_rdy, rdy_wide - b_wide);
        end
    endtask

    task automatic test_rails;
        for (int md = 1; md <= 2; md++) begin
            run_conv(md, 16'h0000, -1, -1);
            n_cmp++;
            if (timed_out || got_data !== 14'(model(md, 0, 14))) begin
                n_err++;
                $display("FAIL rail%0d_data: got %h want %h", md, got_data, 14'(model(md, 0, 14)));
            end
            n_cmp++;
            if (lclk_rises - b_lclk != 14 || sclk_rises - b_sclk != 224) begin
                n_err++;
                $display("FAIL rail%0d_edges: got lclk %0d sclk %0d want 14 224",
                         md, lclk_rises - b_lclk, sclk_rises - b_sclk);
            end
            n_cmp++;
            if (lat_q.size() < b_words + 2 || lat_q[b_words + 1] !== (md == 1 ? 16'hC000 : 16'h4000)) begin
                n_err++;
                $display("FAIL rail%0d_word2: got %0d words want second word %h",
                         md, lat_q.size() - b_words, (md == 1 ? 16'hC000 : 16'h4000));
            end
        end
    endtask

    task automatic test_protocol;
        logic [15:0] th;
        logic [15:0] w0, w1;
        th = 16'($urandom_range(0, 16'hFFFF));
        run_conv(0, th, -1, -1);
        w0 = (lat_q.size() > b_words) ? lat_q[b_words] : 16'hxxxx;
        w1 = (lat_q.size() > b_words + 1) ? lat_q[b_words + 1] : 16'hxxxx;
        n_cmp++;
        if (w0 !== 16'h8000) begin
            n_err++;
            $display("FAIL proto_word1: got %h want 8000", w0);
        end
        n_cmp++;
        if (w1 !== ((16'h8000 <= th) ? 16'hC000 : 16'h4000)) begin
            n_err++;
            $display("FAIL proto_word2: thr %h got %h want %h", th, w1,
                     ((16'h8000 <= th) ? 16'hC000 : 16'h4000));
        end
        n_cmp++;
        if (sh_cycles - b_sh != 16 || overlap != b_ov) begin
            n_err++;
            $display("FAIL proto_sh: got %0d high cycles overlap %0d want 16 0",
                     sh_cycles - b_sh, overlap - b_ov);
        end
        n_cmp++;
        if (ser_err != b_ser) begin
            n_err++;
            $display("FAIL proto_ser_stable: got %0d violations want 0", ser_err - b_ser);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 4; n++) begin
            logic [15:0] th;
            int bad;
            th = 16'($urandom_range(0, 16'hFFFF));
            run_conv(0, th, -1, -1);
            n_cmp++;
            if (timed_out || got_data !== 14'(model(0, th, 14))) begin
                n_err++;
                $display("FAIL rand_data: thr %h got %h want %h", th, got_data, 14'(model(0, th, 14)));
            end
            bad = 0;
            for (int k = 0; k < 14; k++) begin
                if (lat_q.size() <= b_words + k || lat_q[b_words + k] !== 16'(model(0, th, k))) bad++;
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL rand_words: thr %h got %0d bad words want 0", th, bad);
            end
        end
    endtask

    task automatic test_handshake;
        logic [15:0] th;
        int extra;
        th = 16'($urandom_range(0, 16'hFFFF));
        run_conv(0, th, 100, 500);
        n_cmp++;
        if (timed_out || got_data !== 14'(model(0, th, 14)) || got_cyc - acc_cyc !== 1067) begin
            n_err++;
            $display("FAIL hs_ignore: got %h lat %0d want %h lat 1067",
                     got_data, got_cyc - acc_cyc, 14'(model(0, th, 14)));
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdy === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL hs_no_queue: got %0d busy/strobe cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int t[3];
        logic [13:0] d[3];
        int n;
        mode = 0;
        thr  = 16'h2FFF;
        n = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 0; k < 4000 && n < 3; k++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                t[n] = cyc;
                d[n] = data;
                n++;
                if (n == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (n != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d strobes want 3", n);
        end else begin
            n_cmp++;
            if (t[1] - t[0] != 1069 || t[2] - t[1] != 1069) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d %0d want 1069 1069", t[1] - t[0], t[2] - t[1]);
            end
            n_cmp++;
            if (d[0] !== 14'(model(0, 'h2FFF, 14)) || d[1] !== d[0] || d[2] !== d[0]) begin
                n_err++;
                $display("FAIL b2b_data: got %h %h %h want %h", d[0], d[1], d[2], 14'(model(0, 'h2FFF, 14)));
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_stop: got busy %b want 0", busy);
        end
    endtask

    task automatic test_abort;
        int base;
        int strobes;
        bit found;
        mode = 0;
        thr  = 16'h2FFF;
        @(posedge clk); #1;
        base  = lclk_rises;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (lclk_rises - base == 7 && lclk === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (!found || {busy, sh, ser, sclk, lclk, rdy} !== 6'b0 || data !== 14'h0) begin
            n_err++;
            $display("FAIL abort_reset: found %0d got ctrl %b data %h want 000000 0000",
                     found, {busy, sh, ser, sclk, lclk, rdy}, data);
        end
        @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (rdy === 1'b1 || busy === 1'b1) strobes++;
        end
        n_cmp++;
        if (strobes != 0) begin
            n_err++;
            $display("FAIL abort_no_strobe: got %0d busy/strobe cycles want 0", strobes);
        end
        run_conv(0, 16'h2FFF, -1, -1);
        n_cmp++;
        if (timed_out || got_data !== 14'h0BFF || got_cyc - acc_cyc !== 1067) begin
            n_err++;
            $display("FAIL abort_restart: got %h lat %0d want 0bff 1067", got_data, got_cyc - acc_cyc);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_midscale();
        test_rails();
        test_protocol();
        test_random();
        test_handshake();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sar_adc_seq.md
Name: sar_adc_seq

Overview:
- Successive-approximation sequencer for the PmodADC front end.
- Per conversion: drives the sample/hold line, then runs a DATA_W-bit binary search.
  - Each trial code is shifted serially into the board's DAC shift register, latched, left to settle, and judged by the external comparator.
- Presents the result with a one-cycle ready strobe to the downstream logic in the top level.

Parameters:
- DATA_W, 14: result width in bits.
- SHREG_W, 16: DAC shift-register width. Trial code is left-aligned into it: word = trial << (SHREG_W-DATA_W).
- CLK_DIV, 2: clk_i cycles per SCLK/LCLK half-period; minimum 1.
- SETTLE_CYC, 8: cycles between LCLK falling and comparator decision; minimum 1.
- SH_CYC, 16: cycles ADC_SH_o held high (track) before the search starts; minimum 1.

Ports:
- clk_i, input, 1: system clock.
- reset_i, input, 1: synchronous active-high reset.
- start_i, input, 1: conversion request, level-sampled in IDLE.
- busy_o, output, 1: high from start acceptance until the cycle ADC_data_rdy_o is asserted, inclusive.
- ADC_SH_o, output, 1: 1 = track, 0 = hold.
- ADC_Ser_o, output, 1: serial DAC data.
- ADC_SClk_o, output, 1: DAC shift clock; data is taken on the rising edge.
- ADC_LClk_o, output, 1: DAC latch clock; latched on the rising edge.
- ADC_Comp_i, input, 1: comparator. 1 means DAC word <= Vin. Asynchronous to clk_i.
- ADC_data_o, output, DATA_W: last completed result.
- ADC_data_rdy_o, output, 1: one-cycle strobe when ADC_data_o updates.

Behaviour:
- Reset: synchronous, active-high, on the clk_i rising edge.
  - State goes to IDLE.
  - All outputs go to 0: busy_o, ADC_SH_o, ADC_Ser_o, ADC_SClk_o, ADC_LClk_o, ADC_data_o, ADC_data_rdy_o.
  - Comparator synchronizer and all internal registers are cleared.
  - Reset asserted mid-conversion aborts the conversion; no ready strobe is produced.
- ADC_Comp_i passes through a 2-flop synchronizer. Only the synchronized value is used.
- IDLE:
  - SCLK, LCLK and Ser are low; SH is low.
  - When start_i = 1: load trial = 1 << (DATA_W-1), clear the result accumulator, set busy_o, go to SAMPLE.
- SAMPLE:
  - ADC_SH_o = 1 for exactly SH_CYC cycles.
  - Then SH goes to 0 and the state goes to SHIFT with bit index i = DATA_W-1.
- SHIFT:
  - Shifts SHREG_W bits of the DAC word, LSB first.
  - For each bit: Ser is set with SCLK low for CLK_DIV cycles, then SCLK is high for CLK_DIV cycles.
  - Ser is held stable across the whole bit period.
  - After the last bit: SCLK and Ser return low, go to LATCH.
- LATCH: LCLK high for CLK_DIV cycles, then low; go to SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then go to DECIDE.
- DECIDE (1 cycle):
  - If synced comparator = 1, bit i of the accumulator is kept; if 0, it is cleared.
  - If i > 0: set bit i-1, decrement i, go to SHIFT.
  - Otherwise go to DONE.
- DONE (1 cycle):
  - ADC_data_o <= accumulator.
  - ADC_data_rdy_o = 1.
  - busy_o = 1 in this cycle, then clears.
  - Next state is IDLE.
- Per-bit time: T_BIT = 2*CLK_DIV*SHREG_W + CLK_DIV + SETTLE_CYC + 1.
- Latency: the ready strobe occurs SH_CYC + DATA_W*T_BIT + 1 cycles after the start-accept edge. Defaults: T_BIT = 75, latency = 1067.
- start_i while busy is ignored; requests are not queued.
- start_i held high gives back-to-back conversions: one IDLE cycle between the DONE cycle and the next SAMPLE.
- ADC_data_o holds its value between strobes and is unaffected by aborted conversions.

Test Plan:
1. Reset values: after reset_i is held for 3 cycles, all outputs read 0. Start with reset_i high, held 5 cycles → no SH, SCLK or LCLK activity.
2. Mid-scale emulated converter: the bench shift register models the DAC (16-bit, LSB-first shift on SCLK rising edge, copy on LCLK rising edge); comparator = latched word <= 0x2FFF.
   - Pulse start_i → ADC_data_o = 0x0BFF.
   - Ready strobe exactly 1067 cycles after start acceptance, one cycle wide.
3. Rails:
   - Comparator tied 1 → 0x3FFF.
   - Comparator tied 0 → 0x0000.
   - Each case: exactly 14 LCLK pulses and 224 SCLK rising edges per conversion.
4. Protocol check:
   - First latched DAC word = 0x8000.
   - Second word = 0xC000 when comparator = 1, 0x4000 when comparator = 0.
   - ADC_SH_o high for exactly 16 cycles, before the first SCLK edge.
   - Ser stable over every SCLK rising edge.
5. Handshake:
   - start_i pulsed at cycles 100 and 500 of a conversion → ignored, single strobe.
   - start_i held high for 3 conversions → 3 strobes, spaced 1069 cycles apart.
6. Abort:
   - Assert reset_i during the SETTLE of bit 7 → next cycle all outputs 0 and no strobe follows.
   - A fresh start_i afterwards yields a correct 0x0BFF.
